// File: rtl/btn_pkg.sv
// Shared types and default parameters for the push-button conditioner.
// The debounce state encoding is fixed so that state dumps read the same everywhere.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_TICK_DIV      = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Synchronizes and debounces a raw push-button, then turns each debounced press into a
// request held until exactly one step strobe consumes it.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int TICK_DIV      = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic a_out,
  output logic en_out,
  output logic lost
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic          s2;
  db_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          press;
  logic [TW-1:0] tcnt;
  logic          pend;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Any disagreement during a WAIT state restarts the stability count.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    state_n = state;
    cnt_n   = cnt;
    press   = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = WAIT_HI;
          cnt_n   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = HIGH;
          press   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_n = WAIT_LO;
          cnt_n   = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    level = (state == HIGH) || (state == WAIT_LO);
  end

  // Free-running strobe; with TICK_DIV=1 tcnt sits at 0 and en_out is constantly high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tcnt == TICK_LAST) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign en_out = (tcnt == TICK_LAST);

  // A new press beats a same-cycle consume; it only counts as lost if nothing consumed pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      lost <= 1'b0;
    end else begin
      pend <= press | (pend & ~en_out);
      lost <= press & pend & ~en_out;
    end
  end

  assign a_out = pend;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench: two conditioner instances (TICK_DIV 3 and 32) share one button,
// each checked every cycle against a run-length model, plus literal timing checkpoints.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic level3, a3, en3, lost3;
  logic level32, a32, en32, lost32;

  int n_tests = 0;
  int n_fails = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.STABLE_CYCLES(4), .TICK_DIV(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .level   (level3),
    .a_out   (a3),
    .en_out  (en3),
    .lost    (lost3)
  );

  btn_conditioner #(.STABLE_CYCLES(4), .TICK_DIV(32)) dut_m (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .level   (level32),
    .a_out   (a32),
    .en_out  (en32),
    .lost    (lost32)
  );

  // Model: level flips once the synchronized button has disagreed with it for
  // STABLE_CYCLES+1 consecutive edges; strobe is cycle-index arithmetic since reset.
  typedef struct {
    logic s1;
    logic s2;
    logic level;
    logic pend;
    logic lost;
    int   run;
    int   cyc;
  } model_t;

  function automatic model_t step(model_t m, logic btn, int stable, int div);
    model_t n;
    logic   press;
    logic   consume;
    n     = m;
    press = 1'b0;
    if (m.s2 != m.level) begin
      n.run = m.run + 1;
      if (n.run == stable + 1) begin
        n.level = m.s2;
        n.run   = 0;
        press   = m.s2;
      end
    end else begin
      n.run = 0;
    end
    n.s1    = btn;
    n.s2    = m.s1;
    consume = ((m.cyc % div) == div - 1) && m.pend;
    n.pend  = press || (m.pend && !consume);
    n.lost  = press && m.pend && !consume;
    n.cyc   = m.cyc + 1;
    return n;
  endfunction

  function automatic logic model_en(model_t m, int div);
    return (m.cyc % div) == div - 1;
  endfunction

  model_t m3  = '{default: 0};
  model_t m32 = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3  <= '{default: 0};
      m32 <= '{default: 0};
    end else begin
      m3  <= step(m3, btn_raw, 4, 3);
      m32 <= step(m32, btn_raw, 4, 32);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m3.level",  level3,  m3.level);
    check("m3.a_out",  a3,      m3.pend);
    check("m3.en_out", en3,     model_en(m3, 3));
    check("m3.lost",   lost3,   m3.lost);
    check("m32.level", level32, m32.level);
    check("m32.a_out", a32,     m32.pend);
    check("m32.en_out", en32,   model_en(m32, 32));
    check("m32.lost",  lost32,  m32.lost);
  end

  // Returns 1 ns after the n-th following rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit [5:0] en_pat;
    int       n_cons;
    int       n_lost;
    logic     seen;

    rst_n   = 1'b0;
    btn_raw = 1'b1;

    // Reset held with the button pressed
    cyc(3);
    check("rst.level", level3, 1'b0);
    check("rst.a_out", a3, 1'b0);
    check("rst.en_out", en3, 1'b0);
    check("rst.lost", lost3, 1'b0);

    rst_n   = 1'b1;
    btn_raw = 1'b0;
    en_pat  = 6'b100100;
    check("tick.c0", en3, en_pat[0]);
    for (int k = 1; k < 6; k++) begin
      cyc(1);
      check($sformatf("tick.c%0d", k), en3, en_pat[k]);
    end
    cyc(10);

    // Clean press: e0 is the next edge
    btn_raw = 1'b1;
    cyc(6);
    check("press.level_e5", level3, 1'b0);
    check("press.a_e5", a3, 1'b0);
    cyc(1);
    check("press.level_e6", level3, 1'b1);
    check("press.a_e6", a3, 1'b1);
    n_cons = 0;
    for (int i = 0; i < 4; i++) begin
      if (a3 && en3) n_cons++;
      cyc(1);
    end
    check("press.consumes", n_cons, 1);
    check("press.a_cleared", a3, 1'b0);
    btn_raw = 1'b0;
    cyc(12);
    check("press.released", level3, 1'b0);

    // Bounce 1,0,1,1,0,1 then hold
    begin
      bit [5:0] pat;
      pat = 6'b101101;
      for (int i = 0; i < 6; i++) begin
        btn_raw = pat[i];
        cyc(1);
      end
    end
    cyc(5);
    check("bounce.level_e5", level3, 1'b0);
    check("bounce.a_e5", a3, 1'b0);
    cyc(1);
    check("bounce.level_e6", level3, 1'b1);
    btn_raw = 1'b0;
    cyc(12);

    // Short glitch of 3 cycles
    btn_raw = 1'b1;
    cyc(3);
    btn_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      seen = seen | level3 | a3;
    end
    check("glitch.no_rise", seen, 1'b0);

    // Async reset mid-WAIT_HI, without a clock edge
    btn_raw = 1'b1;
    cyc(4);
    #2 rst_n = 1'b0;
    #1;
    check("areset1.level", level3, 1'b0);
    check("areset1.a_out", a3, 1'b0);
    check("areset1.en_out", en3, 1'b0);
    cyc(2);

    // Async reset while a request is pending
    rst_n = 1'b1;
    cyc(7);
    check("areset2.a_before", a3, 1'b1);
    check("areset2.a32_before", a32, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("areset2.a_out", a3, 1'b0);
    check("areset2.level", level3, 1'b0);
    check("areset2.a32_out", a32, 1'b0);
    btn_raw = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    check("areset2.no_survivor", a3, 1'b0);
    check("areset2.no_survivor32", a32, 1'b0);

    // Merge: presses land at edges 7 and 17; TICK_DIV=32 consumes at edge 32
    rst_n = 1'b0;
    cyc(2);
    rst_n   = 1'b1;
    btn_raw = 1'b1;
    cyc(5);
    btn_raw = 1'b0;
    cyc(5);
    btn_raw = 1'b1;
    n_lost = 0;
    n_cons = 0;
    for (int k = 11; k <= 40; k++) begin
      cyc(1);
      if (lost32) n_lost++;
      if (a32 && en32) n_cons++;
      if (k == 17) check("merge.lost_e17", lost32, 1'b1);
      if (k == 31) check("merge.a_e31", a32, 1'b1);
      if (k == 32) check("merge.a_e32", a32, 1'b0);
    end
    check("merge.lost_count", n_lost, 1);
    check("merge.consumes", n_cons, 1);
    btn_raw = 1'b0;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
